// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl - reorder-buffer allocation controller for the decode stage.
//
// Keeps the ROB head/tail pointers and the occupancy count. Decode gets the
// next free tag on robAllocation and a freeze request on fullRob. Commits
// retire the head entry. A flush empties the ROB and then holds allocation
// off for RECOVER cycles while register status is restored.
//
// Parameters:
//   ROB      tag MSB index; tags are ROB+1 bits, depth = 2**(ROB+1)
//   RECOVER  cycles fullRob stays high after a flush (1..7)
//
// Ports:
//   clk            clock
//   globalReset    asynchronous active-high reset
//   robReq         decode dispatches one instruction (honoured only when fullRob=0)
//   validCommit    head entry retires this cycle
//   flush          control-flow recovery, synchronous
//   robAllocation  tag for the instruction in decode (the tail pointer)
//   commitROB      current head tag
//   fullRob        no free entry, or recovering from a flush
//   emptyRob       occupancy is zero
//   robCount       occupancy, 0..DEPTH
//   allocAck       registered, high the cycle after a successful allocation
//
// Optional feature macro: ROB_FULL_BYPASS_EN
//   When defined, a commit from a full ROB frees its slot for a same-cycle
//   allocation, which puts validCommit on the combinational path to fullRob.
//   When undefined, fullRob depends on registered state only.

module rob_alloc_ctrl #(
   parameter int ROB     = 2,
   parameter int RECOVER = 1
) (
   input  logic           clk,
   input  logic           globalReset,
   input  logic           robReq,
   input  logic           validCommit,
   input  logic           flush,
   output logic [ROB:0]   robAllocation,
   output logic [ROB:0]   commitROB,
   output logic           fullRob,
   output logic           emptyRob,
   output logic [ROB+1:0] robCount,
   output logic           allocAck
);

   localparam int               DEPTH       = 2 ** (ROB + 1);
   localparam logic [ROB+1:0]   DEPTH_CNT   = (ROB + 2)'(DEPTH);
   localparam logic [ROB+1:0]   CNT_ONE     = (ROB + 2)'(1);
   localparam logic [ROB:0]     TAG_ONE     = (ROB + 1)'(1);
   localparam logic [2:0]       RECOVER_CNT = 3'(RECOVER);

   typedef enum logic {
      ST_RUN,
      ST_RECOVER
   } state_t;

   state_t         state;
   logic [2:0]     recover_cnt;
   logic [ROB:0]   head;
   logic [ROB:0]   tail;
   logic [ROB+1:0] count;
   logic           is_full;
   logic           do_alloc;
   logic           do_commit;
   logic [ROB:0]   head_inc;

   // Full and empty come from the count so that head == tail is never ambiguous.
   assign is_full  = (count == DEPTH_CNT);
   assign emptyRob = (count == '0);

`ifdef ROB_FULL_BYPASS_EN
   // A retiring head entry on a full ROB makes its slot available this cycle.
   assign fullRob = (is_full & ~(validCommit & ~flush & (state == ST_RUN)))
                  | (state == ST_RECOVER);
`else
   assign fullRob = is_full | (state == ST_RECOVER);
`endif

   assign do_alloc  = robReq & ~fullRob & ~flush;
   assign do_commit = validCommit & ~emptyRob;
   assign head_inc  = head + TAG_ONE;

   assign robAllocation = tail;
   assign commitROB     = head;
   assign robCount      = count;

   // Pointer, count and recovery state machine. A flush wins over allocation:
   // the ROB collapses to the (possibly advanced) head and allocation is held
   // off until the recovery countdown expires.
   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         state       <= ST_RUN;
         recover_cnt <= '0;
         allocAck    <= 1'b0;
      end else if (flush) begin
         head        <= do_commit ? head_inc : head;
         tail        <= do_commit ? head_inc : head;
         count       <= '0;
         allocAck    <= 1'b0;
         state       <= ST_RECOVER;
         recover_cnt <= RECOVER_CNT;
      end else begin
         allocAck <= do_alloc;
         if (do_alloc) begin
            tail <= tail + TAG_ONE;
         end
         if (do_commit) begin
            head <= head_inc;
         end
         if (do_alloc && !do_commit) begin
            count <= count + CNT_ONE;
         end else if (!do_alloc && do_commit) begin
            count <= count - CNT_ONE;
         end
         if (state == ST_RECOVER) begin
            if (recover_cnt <= 3'd1) begin
               state       <= ST_RUN;
               recover_cnt <= '0;
            end else begin
               recover_cnt <= recover_cnt - 3'd1;
            end
         end
      end
   end

endmodule

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
Reorder-buffer allocation controller feeding the instruction decode stage. Owns the ROB head/tail pointers and the occupancy count. Hands decode the next free ROB tag (robAllocation) and the fullRob stall. Retires entries on commit and empties the ROB on a control-flow flush, then holds allocation off for a short recovery window while register status is restored.

Parameters:
ROB, 2, ROB tag MSB index; tags are ROB+1 bits, depth = 2**(ROB+1) = 8
RECOVER, 1, cycles fullRob is held high after a flush (range 1-7)

Ports:
clk  input  1  clock
globalReset  input  1  asynchronous active-high reset
robReq  input  1  decode dispatches one instruction this cycle; only acted on when fullRob=0
validCommit  input  1  head entry retires this cycle
flush  input  1  control-flow recovery (robBus.controlFlow[0]); synchronous
robAllocation  output  ROB+1  tag for the instruction in decode (= tail), combinational from registers
commitROB  output  ROB+1  current head tag
fullRob  output  1  no free entry or recovering; decode freezes
emptyRob  output  1  count == 0
robCount  output  ROB+2  current occupancy, 0..DEPTH
allocAck  output  1  registered; 1 the cycle after a successful allocation

Behaviour:
- Reset (async, globalReset=1) sets head=0, tail=0, count=0, state=RUN, recoverCnt=0 and allocAck=0. Outputs then read robAllocation=0, commitROB=0, fullRob=0, emptyRob=1, robCount=0.
- State machine:
  - RUN: normal operation.
  - RECOVER: entered on flush. Stays RECOVER for RECOVER cycles (recoverCnt counts down), then returns to RUN.
  - A flush seen while in RECOVER reloads recoverCnt and stays in RECOVER.
- fullRob = (count == DEPTH) | (state == RECOVER). It is combinational from registers only and never depends on robReq or validCommit (unless ROB_FULL_BYPASS_EN is defined).
- Allocation: doAlloc = robReq & ~fullRob & ~flush. When doAlloc is 1, tail <= tail+1 (mod DEPTH, natural wrap from 7 to 0) and allocAck <= 1 next cycle; otherwise allocAck <= 0.
- Commit: doCommit = validCommit & ~emptyRob. When doCommit is 1, head <= head+1 (mod DEPTH). validCommit while empty is ignored.
- Count update: count <= count + doAlloc - doCommit, with width ROB+2 so that DEPTH is representable. Simultaneous alloc and commit leaves count unchanged.
- Flush has priority over everything else:
  - If validCommit=1 the same cycle, head <= head+1 (the flushing instruction retires).
  - tail <= new head; count <= 0; allocation blocked; state <= RECOVER; recoverCnt <= RECOVER.
- When count == DEPTH and validCommit=1, a robReq in that cycle is refused because fullRob=1. The entry becomes available the following cycle (no same-cycle bypass).
- Full/empty both derive from count, never from head == tail comparison.
- There is zero latency from the tail register to robAllocation. Decode latches robAllocation on its non-frozen edge, which is the same edge at which tail advances.

Optional Feature:
ROB_FULL_BYPASS_EN
- Defined: when count == DEPTH and validCommit=1 (no flush, state RUN), fullRob = 0 that cycle. A robReq then allocates into the freed slot: tail and head both advance and count stays DEPTH. This adds a combinational path validCommit -> fullRob.
- Undefined: behaviour exactly as in Behaviour above. fullRob is purely registered-state-derived.

Test Plan:
- Reset then 8 back-to-back robReq, no commits -> robAllocation 0..7 on successive cycles, robCount=8, fullRob=1; the 9th robReq is refused (tail stays 0, allocAck=0).
- From full (head=0), assert validCommit and robReq together:
  - Without the macro -> count 7, tail unchanged; next-cycle robReq is accepted with tag 0.
  - With ROB_FULL_BYPASS_EN -> same-cycle accept, head=1, tail=1, count=8.
- Wrap: alloc 6, commit 6, alloc 4 -> tags issued 6,7,0,1; head=6, tail=2, count=4, emptyRob=0.
- Flush with head=3, tail=6, validCommit=1 -> next cycle head=4, tail=4, count=0, fullRob=1 for RECOVER=1 cycle; robReq during RECOVER is ignored; the following robReq gets tag 4.
- Flush again during RECOVER (RECOVER=3) -> recoverCnt reloads to 3, fullRob stays high 3 more cycles.
- Assert globalReset mid-stream (count=5) asynchronously between edges -> all outputs return to reset values immediately, without waiting for clk.
